// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DSTALL = 2'd1,
    MDWAIT = 2'd2
  } hz_state_e;

  // Canonical RV32I NOP (addi x0, x0, 0) loaded into IF/ID on a flush.
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // True when a used, nonzero source register matches a destination register.
  // Register addresses are zero-extended to 32 bits by the caller.
  function automatic logic reg_match(input logic        use_rs,
                                     input logic [31:0] rs,
                                     input logic [31:0] rd);
    return use_rs && (rs != 32'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard term generation: load-use, branch-after-ALU,
// branch-after-load in EX and branch-after-load in MEM.
module hazard_detect #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_mem_read,
  output logic              lu,
  output logic              ba,
  output logic              bl2,
  output logic              bl1
);
  import hazard_pkg::*;

  logic ex_hit;
  logic mem_hit;

  // Source/destination matches and the four hazard terms.
  always_comb begin
    ex_hit  = reg_match(id_use_rs1, 32'(id_rs1), 32'(ex_rd)) ||
              reg_match(id_use_rs2, 32'(id_rs2), 32'(ex_rd));
    mem_hit = reg_match(id_use_rs1, 32'(id_rs1), 32'(mem_rd)) ||
              reg_match(id_use_rs2, 32'(id_rs2), 32'(mem_rd));
    lu      = !id_is_branch && ex_hit && ex_mem_read;
    ba      = id_is_branch && ex_hit && ex_reg_write && !ex_mem_read;
    bl2     = id_is_branch && ex_hit && ex_mem_read;
    bl1     = id_is_branch && mem_hit && mem_mem_read;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_branch,
  input  logic              id_branch_taken,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_mem_read,
  input  logic              ex_md_start,
  output logic              pc_ce,
  output logic              if_id_ce,
  output logic              if_id_cstall,
  output logic              id_ex_ce,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              md_busy,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);
  import hazard_pkg::*;

  // The start cycle counts as the first of MD_LATENCY EX cycles.
  localparam logic [3:0] MdCnt = 4'(MD_LATENCY - 1);

  hz_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu, ba, bl2, bl1;

  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_detect (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_is_branch (id_is_branch),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .mem_rd       (mem_rd),
    .mem_mem_read (mem_mem_read),
    .lu           (lu),
    .ba           (ba),
    .bl2          (bl2),
    .bl1          (bl1)
  );

  // State and occupancy counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline register controls.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_ce        = 1'b1;
    if_id_ce     = 1'b1;
    id_ex_ce     = 1'b1;
    if_id_cstall = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = 1'b0;
    unique case (state_q)
      RUN: begin
        if (ex_md_start) begin
          state_d      = MDWAIT;
          cnt_d        = MdCnt;
          pc_ce        = 1'b0;
          if_id_ce     = 1'b0;
          id_ex_ce     = 1'b0;
          ex_mem_flush = 1'b1;
          md_busy      = 1'b1;
        end else if (bl2) begin
          state_d     = DSTALL;
          cnt_d       = 4'd1;
          pc_ce       = 1'b0;
          if_id_ce    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (lu || ba || bl1) begin
          pc_ce       = 1'b0;
          if_id_ce    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (id_is_branch && id_branch_taken) begin
          if_id_cstall = 1'b1;
        end
      end
      DSTALL: begin
        pc_ce       = 1'b0;
        if_id_ce    = 1'b0;
        id_ex_flush = 1'b1;
        cnt_d       = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      MDWAIT: begin
        pc_ce        = 1'b0;
        if_id_ce     = 1'b0;
        id_ex_ce     = 1'b0;
        md_busy      = 1'b1;
        ex_mem_flush = 1'b1;
        cnt_d        = cnt_q - 4'd1;
        // Final EX cycle: let EX/MEM capture the MUL/DIV result.
        if (cnt_q <= 4'd1) begin
          state_d      = RUN;
          cnt_d        = '0;
          ex_mem_flush = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (rst) begin
      pc_ce        = 1'b0;
      if_id_ce     = 1'b0;
      id_ex_ce     = 1'b0;
      if_id_cstall = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      md_busy      = 1'b0;
    end
  end

  // A new MUL/DIV cannot enter EX while the pipeline is held.
  md_start_in_run: assert property (@(posedge clk) disable iff (rst)
    !(ex_md_start && (state_q != RUN)));

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating stall-cycle and flush-event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_ce && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_cstall && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RV32I pipeline.
- Decides the pipeline register controls each cycle: PC, IF/ID, ID/EX and EX/MEM enables and flushes.
- Covers load-use hazards, branch operand dependencies (branches resolve in ID), taken-branch flush, and multi-cycle MUL/DIV occupancy of EX.
- Sits beside the decoder; its outputs feed the PC register and every pipeline register's CE and flush inputs.

Parameters:
- MD_LATENCY, 4, total EX cycles of a MUL/DIV op; legal range 2..16.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  instruction in ID reads that source.
- id_is_branch  in  1  ID holds a branch or JALR (compared in ID).
- id_branch_taken  in  1  branch comparator result; valid only with id_is_branch.
- ex_rd  in  REG_AW  destination register of the instruction in EX.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_mem_read  in  1  EX instruction is a load.
- mem_rd  in  REG_AW  destination register of the instruction in MEM.
- mem_mem_read  in  1  MEM instruction is a load.
- ex_md_start  in  1  a MUL/DIV is in EX this cycle, first cycle only.
- pc_ce  out  1  PC update enable.
- if_id_ce  out  1  IF/ID capture enable.
- if_id_cstall  out  1  load NOP (0x00000013) into IF/ID.
- id_ex_ce  out  1  ID/EX capture enable.
- id_ex_flush  out  1  load bubble into ID/EX.
- ex_mem_flush  out  1  load bubble into EX/MEM.
- md_busy  out  1  MUL/DIV occupying EX.
- perf_stall_cnt  out  32  stall-cycle count; see Optional Feature.
- perf_flush_cnt  out  32  flush-event count; see Optional Feature.

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high; all state updates on rising clk.
- While rst=1:
  - Outputs forced: pc_ce=0, if_id_ce=0, id_ex_ce=0, if_id_cstall=1, id_ex_flush=1, ex_mem_flush=1, md_busy=0.
  - FSM is loaded with RUN; counters are cleared.
- Dependency match requires a nonzero source register. x0 never causes a hazard.
- Hazard terms, combinational from ports:
  - LU (load-use): non-branch in ID, any used rs equals ex_rd, ex_mem_read=1.
  - BA (branch after ALU): branch in ID, used rs equals ex_rd, ex_reg_write=1, ex_mem_read=0.
  - BL2 (branch after load in EX): branch in ID, used rs equals ex_rd, ex_mem_read=1.
  - BL1 (branch after load in MEM): branch in ID, used rs equals mem_rd, mem_mem_read=1.
- FSM states, encoded as 2 bits: RUN, DSTALL, MDWAIT. Counter cnt is 4 bits.
- RUN, priority order:
  1. ex_md_start: go to MDWAIT with cnt=MD_LATENCY-1. Same cycle: pc_ce=0, if_id_ce=0, id_ex_ce=0, ex_mem_flush=1, md_busy=1.
  2. BL2: go to DSTALL with cnt=1. Same cycle: pc_ce=0, if_id_ce=0, id_ex_flush=1.
  3. LU, BA or BL1: 1-cycle stall; stay in RUN. Same cycle: pc_ce=0, if_id_ce=0, id_ex_flush=1. The term re-evaluates next cycle once the producer has advanced.
  4. id_is_branch and id_branch_taken: if_id_cstall=1, pc_ce=1 (PC takes target), id_ex_ce=1.
  5. Otherwise all CEs=1, all flushes=0.
- DSTALL: same outputs as rule 2.
  - cnt decrements each cycle.
  - At cnt=0 return to RUN; the branch re-evaluates in RUN, where BL1 normally no longer holds.
- MDWAIT:
  - pc_ce=0, if_id_ce=0, id_ex_ce=0, ex_mem_flush=1, md_busy=1; cnt decrements.
  - At cnt=0 return to RUN with ex_mem_flush=0, so the result is captured by EX/MEM that cycle.
  - Total EX occupancy is exactly MD_LATENCY cycles.
- Simultaneous events:
  - A taken branch is ignored while any stall term or non-RUN state is active, because its operands are not yet valid.
  - ex_md_start arriving in DSTALL or MDWAIT is impossible by construction; an assertion flags it.
- rst asserted mid-DSTALL or mid-MDWAIT aborts to RUN next cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with pc_ce=0 and rst=0.
  - perf_flush_cnt increments on every cycle with if_id_cstall=1 and rst=0.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: both ports are driven constant 0 and no counter flops are generated.

Decomposition:
- Package hazard_pkg holds:
  - The state enum (RUN=2'd0, DSTALL=2'd1, MDWAIT=2'd2).
  - NOP_INST=32'h00000013.
  - The hazard-match function (rs, use, rd; x0 excluded).
- Natural sub-module: hazard_detect, purely combinational, producing LU/BA/BL1/BL2.
- FSM, counter and perf counters stay in hazard_ctrl.

Test Plan:
- Load-use: lw x5 in EX (ex_rd=5, ex_mem_read=1), add reads x5 in ID. Expect exactly 1 cycle of pc_ce=0, if_id_ce=0, id_ex_flush=1, then RUN.
- Branch after load: beq reads x7, lw x7 in EX. Expect DSTALL for 2 cycles, then taken branch gives if_id_cstall=1 for one cycle.
- Branch after ALU: addi x3 in EX, bne reads x3. Expect 1 stall cycle, then branch resolves. Same stimulus with x0: no stall.
- MUL/DIV: ex_md_start with MD_LATENCY=4. Expect md_busy=1 and ex_mem_flush=1 for 3 cycles, 4th cycle ex_mem_flush=0, PC resumes on cycle 5.
- Reset mid-MDWAIT: rst at cnt=2. Expect forced reset outputs, then RUN with all CEs=1 on the first post-reset cycle.
- HAZARD_PERF_EN: run the four scenarios above in sequence. Expect perf_stall_cnt=1+2+1+4=8 and perf_flush_cnt=1.
